mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the exec unit's single-port byte memory between two requesters: instruction fetch and data load/store.
- Instructions are 16 bits, stored as two consecutive bytes, high byte first. Each fetch is sequenced as two back-to-back byte reads.
- Sits between the fetch/decode logic and the memory instance inside exec_unit; it is the only master driving the memory port.

Parameters:
ADDR_BITS, 8, memory address width; addresses wrap modulo 2^ADDR_BITS
DATA_BITS, 8, memory word width; fetch_instr is 2*DATA_BITS

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
fetch_req  in  1  fetch request; held with fetch_addr stable until fetch_gnt
fetch_addr  in  ADDR_BITS  address of the instruction's high byte
fetch_gnt  out  1  one-cycle pulse: fetch accepted this cycle
fetch_valid  out  1  one-cycle pulse: fetch_instr holds the new instruction
fetch_instr  out  2*DATA_BITS  {mem[a], mem[a+1]}; held until next fetch_valid
data_req  in  1  data request; held with data_we/addr/wdata stable until data_gnt
data_we  in  1  1 = store, 0 = load
data_addr  in  ADDR_BITS  data address
data_wdata  in  DATA_BITS  store data
data_gnt  out  1  one-cycle pulse: data request accepted this cycle
data_valid  out  1  one-cycle pulse: data_rdata valid (loads only)
data_rdata  out  DATA_BITS  load result; held until next data_valid
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable, only with mem_en
mem_addr  out  ADDR_BITS  memory address
mem_wdata  out  DATA_BITS  memory write data
mem_rdata  in  DATA_BITS  read data, valid the cycle after mem_en with mem_we=0
arb_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - fetch_valid, data_valid, fetch_gnt, data_gnt, mem_en and mem_we are 0.
  - fetch_instr, data_rdata and the internal address/byte registers are 0.
  - No grant is issued while reset is low.
  - A transaction in flight at reset is abandoned; no valid is produced for it.
- FSM states: IDLE, F_HI, F_LO, D_RD.
- IDLE:
  - Arbitrates on that cycle's requests.
  - Grants and the first memory command are combinational in the grant cycle.
- Arbitration (default): data_req has fixed priority over fetch_req.
- Fetch (grant in cycle N):
  - N: fetch_gnt=1, mem_en=1, mem_we=0, mem_addr=fetch_addr; address latched; next state F_HI.
  - N+1 (F_HI): capture mem_rdata as high byte; mem_en=1, mem_addr=latched+1 (wraps, e.g. 0xFF -> 0x00); next F_LO.
  - N+2 (F_LO): capture mem_rdata as low byte; no memory access; next IDLE.
  - N+3: fetch_valid=1; fetch_instr={hi,lo}. New grants are allowed in this same cycle (IDLE).
- Load (grant in cycle N):
  - N: data_gnt=1, mem_en=1, mem_we=0, mem_addr=data_addr; next D_RD.
  - N+1 (D_RD): capture mem_rdata; next IDLE.
  - N+2: data_valid=1 with data_rdata.
- Store (grant in cycle N):
  - N: data_gnt=1, mem_en=1, mem_we=1, mem_addr=data_addr, mem_wdata=data_wdata.
  - State stays IDLE; the write completes at the end of N.
  - No data_valid for stores.
  - Back-to-back stores: one per cycle.
- Outside a grant or F_HI cycle: mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last value.
- Requests arriving while not IDLE wait; gnt is never asserted outside IDLE.
- A req dropped before gnt is a protocol violation; the arbiter takes no action.
- Throughput limits: at most one fetch per 3 cycles, one load per 2 cycles.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-granted register is reset to "fetch".
  - On simultaneous requests, grant the requester not granted last.
  - A single requester is always granted.
- Undefined: fixed data priority as above; no last-granted register exists.

Test Plan:
- Fetch, mem[0x02]=0x21, mem[0x03]=0x01; fetch_req with addr 0x02 in cycle N -> fetch_gnt in N, mem_addr 0x02 then 0x03, fetch_valid in N+3, fetch_instr=0x2101, arb_busy high in N+1..N+2.
- Wrap, mem[0xFF]=0xA5, mem[0x00]=0x5A; fetch addr 0xFF -> second mem_addr=0x00, fetch_instr=0xA55A.
- Store 0x10 to addr 0x07, then load 0x07 next cycle -> store granted cycle N with mem_we=1; load granted N+1; data_valid in N+3 with data_rdata=0x10.
- Simultaneous fetch_req (addr 0x06) and data load (addr 0x10), repeated 3 times:
  - Default: data granted first every time; the fetch is granted only after the load finishes.
  - With MEM_ARB_RR_EN: grants alternate data, fetch, data.
- Reset asserted in F_HI of a fetch -> all outputs zero immediately, no fetch_valid later. After release, a new fetch of 0x02 returns 0x2101 normally.
- Stores to 0x20..0x23 on consecutive cycles (data_req held high, address advanced after each gnt) -> data_gnt high 4 consecutive cycles, memory holds all 4 bytes, arb_busy stays 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter and its requesters and memory.
// The slave modport is the arbiter side; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                   fetch_req;
    logic [ADDR_BITS-1:0]   fetch_addr;
    logic                   fetch_gnt;
    logic                   fetch_valid;
    logic [2*DATA_BITS-1:0] fetch_instr;

    logic                   data_req;
    logic                   data_we;
    logic [ADDR_BITS-1:0]   data_addr;
    logic [DATA_BITS-1:0]   data_wdata;
    logic                   data_gnt;
    logic                   data_valid;
    logic [DATA_BITS-1:0]   data_rdata;

    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic [DATA_BITS-1:0]   mem_wdata;
    logic [DATA_BITS-1:0]   mem_rdata;

    logic                   arb_busy;

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_instr, data_gnt, data_valid, data_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, arb_busy
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_instr, data_gnt, data_valid, data_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, arb_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares a single-port byte memory between 16-bit instruction fetch and data load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_arbiter #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] F_HI = 2'd1;
    localparam logic [1:0] F_LO = 2'd2;
    localparam logic [1:0] D_RD = 2'd3;

    logic [1:0]             r_state;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [ADDR_BITS-1:0]   r_mem_addr;
    logic [DATA_BITS-1:0]   r_mem_wdata;
    logic [DATA_BITS-1:0]   r_hi;
    logic [DATA_BITS-1:0]   r_rdata;
    logic [2*DATA_BITS-1:0] r_instr;
    logic                   r_fvalid;
    logic                   r_dvalid;

    logic                   w_idle;
    logic                   w_data_first;
    logic                   w_gnt_d;
    logic                   w_gnt_f;
    logic [ADDR_BITS-1:0]   w_mem_addr;
    logic [DATA_BITS-1:0]   w_mem_wdata;

`ifdef MEM_ARB_RR_EN
    logic r_last_fetch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_fetch <= 1'b1;
        end else if (w_gnt_d) begin
            r_last_fetch <= 1'b0;
        end else if (w_gnt_f) begin
            r_last_fetch <= 1'b1;
        end
    end

    assign w_data_first = r_last_fetch;
`else
    assign w_data_first = 1'b1;
`endif

    // Grants are gated by reset so nothing is granted while it is held low.
    assign w_idle  = (r_state == IDLE) && reset;
    assign w_gnt_d = w_idle && bus.data_req && (w_data_first || !bus.fetch_req);
    assign w_gnt_f = w_idle && bus.fetch_req && !w_gnt_d;

    always_comb begin
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        if (w_gnt_d) begin
            w_mem_addr = bus.data_addr;
            if (bus.data_we) w_mem_wdata = bus.data_wdata;
        end else if (w_gnt_f) begin
            w_mem_addr = bus.fetch_addr;
        end else if (r_state == F_HI) begin
            w_mem_addr = r_addr + ADDR_BITS'(1);
        end
    end

    assign bus.fetch_gnt   = w_gnt_f;
    assign bus.data_gnt    = w_gnt_d;
    assign bus.mem_en      = w_gnt_d || w_gnt_f || (r_state == F_HI);
    assign bus.mem_we      = w_gnt_d && bus.data_we;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.fetch_valid = r_fvalid;
    assign bus.fetch_instr = r_instr;
    assign bus.data_valid  = r_dvalid;
    assign bus.data_rdata  = r_rdata;
    assign bus.arb_busy    = (r_state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hi        <= '0;
            r_rdata     <= '0;
            r_instr     <= '0;
            r_fvalid    <= 1'b0;
            r_dvalid    <= 1'b0;
        end else begin
            r_fvalid    <= 1'b0;
            r_dvalid    <= 1'b0;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            case (r_state)
                IDLE: begin
                    if (w_gnt_d && !bus.data_we) begin
                        r_state <= D_RD;
                    end else if (w_gnt_f) begin
                        r_addr  <= bus.fetch_addr;
                        r_state <= F_HI;
                    end
                end
                F_HI: begin
                    r_hi    <= bus.mem_rdata;
                    r_state <= F_LO;
                end
                F_LO: begin
                    r_instr  <= {r_hi, bus.mem_rdata};
                    r_fvalid <= 1'b1;
                    r_state  <= IDLE;
                end
                D_RD: begin
                    r_rdata  <= bus.mem_rdata;
                    r_dvalid <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
